// File: rtl/alu_bist_ctrl.sv
`default_nettype none
// alu_bist_ctrl: BIST sequencer for a 4-bit ALU. It applies pseudo-random stimulus and compacts results into a 16-bit MISR.
// Option ALU_BIST_EXHAUSTIVE_EN replaces the LFSR with a 10-bit counter that covers all 1024 patterns. Rev 1.0
module alu_bist_ctrl #(
  parameter int unsigned NUM_PAT    = 100,
  parameter logic [9:0]  LFSR_SEED  = 10'h001,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  alu_c,
  output logic [3:0]  alu_a,
  output logic [1:0]  alu_op,
  output logic [3:0]  alu_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [9:0]  pat_cnt
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_apply   = 2'd1;
  localparam logic [1:0] c_capture = 2'd2;
  localparam logic [1:0] c_done    = 2'd3;

`ifdef ALU_BIST_EXHAUSTIVE_EN
  localparam logic [9:0] c_pat_init = 10'h000;
`else
  localparam logic [9:0] c_pat_init = LFSR_SEED;
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [9:0]  r_pat;
  logic [9:0]  w_pat_next;
  logic [9:0]  r_stim;
  logic [15:0] r_sig;
  logic [15:0] w_sig_next;
  logic [9:0]  r_cnt;
  logic        r_pass;
  logic        w_last;
  logic        w_start_acc;

`ifdef ALU_BIST_EXHAUSTIVE_EN
  assign w_pat_next = r_pat + 10'd1;
  assign w_last     = (r_cnt == 10'h3FF);
`else
  assign w_pat_next = {r_pat[8:0], r_pat[9] ^ r_pat[6]};
  assign w_last     = (({1'b0, r_cnt} + 11'd1) >= 11'(NUM_PAT));
`endif

  assign w_sig_next  = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h8005 : 16'h0000) ^ {12'h000, alu_c};
  assign w_start_acc = start && ((r_state == c_idle) || (r_state == c_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle, c_done: if (start) w_state_next = c_apply;
      c_apply:        w_state_next = c_capture;
      c_capture:      w_state_next = w_last ? c_done : c_apply;
      default:        w_state_next = c_idle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_apply, c_capture: busy = 1'b1;
      c_done:             done = 1'b1;
      default:            ;
    endcase
  end

  // Stimulus register is loaded on APPLY entry so it stays stable through CAPTURE and holds in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat  <= c_pat_init;
      r_stim <= 10'h000;
      r_sig  <= 16'h0000;
      r_cnt  <= 10'h000;
      r_pass <= 1'b0;
    end else if (w_start_acc) begin
      r_pat  <= c_pat_init;
      r_stim <= c_pat_init;
      r_sig  <= 16'h0000;
      r_cnt  <= 10'h000;
      r_pass <= 1'b0;
    end else if (r_state == c_capture) begin
      r_pat <= w_pat_next;
      r_sig <= w_sig_next;
      r_cnt <= r_cnt + 10'd1;
      if (w_last) begin
        r_pass <= (w_sig_next == GOLDEN_SIG);
      end else begin
        r_stim <= w_pat_next;
      end
    end
  end

  assign alu_a     = r_stim[9:6];
  assign alu_op    = r_stim[5:4];
  assign alu_b     = r_stim[3:0];
  assign signature = r_sig;
  assign pat_cnt   = r_cnt;
  assign pass      = r_pass;

endmodule
`default_nettype wire

// File: doc/alu_bist_ctrl.md
ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

Interface
REQ-001 SHALL have parameter NUM_PAT, default 100, meaning the number of patterns applied per run (legal range 1..1023).
REQ-002 SHALL have parameter LFSR_SEED, default 10'h001, meaning the first pattern (non-zero).
REQ-003 SHALL have parameter GOLDEN_SIG, default 16'h0000, meaning the expected final signature.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled in IDLE or DONE.
REQ-007 SHALL have port alu_c, input, 4 bits: ALU result C, the response to the applied pattern.
REQ-008 SHALL have ports alu_a (4), alu_op (2) and alu_b (4), outputs, registered: the ALU stimulus.
REQ-009 SHALL have port busy, output, 1 bit: high in APPLY or CAPTURE.
REQ-010 SHALL have port done, output, 1 bit: high while in DONE.
REQ-011 SHALL have port pass, output, 1 bit: signature equals GOLDEN_SIG; valid only while done=1.
REQ-012 SHALL have port signature, output, 16 bits: the MISR contents.
REQ-013 SHALL have port pat_cnt, output, 10 bits: the number of patterns captured so far in the current run.

Function
REQ-014 SHALL implement an FSM with states IDLE, APPLY, CAPTURE and DONE.
REQ-015 SHALL transition as follows: IDLE/DONE -> APPLY on start=1; APPLY -> CAPTURE unconditionally; CAPTURE -> APPLY if pat_cnt+1 < NUM_PAT, else CAPTURE -> DONE; DONE holds until start=1.
REQ-016 SHALL, on start accepted, clear signature and pat_cnt to 0, load the LFSR with LFSR_SEED, and clear pass.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL drive {alu_a, alu_op, alu_b} = lfsr[9:0] (alu_a = bits 9:6, alu_op = bits 5:4, alu_b = bits 3:0) during APPLY and CAPTURE, so the stimulus is stable for both cycles.
REQ-019 SHALL use a 10-bit Fibonacci LFSR advanced on CAPTURE exit: next = {lfsr[8:0], lfsr[9]^lfsr[6]}.
REQ-020 SHALL, in CAPTURE, update the MISR as sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h8005 : 16'h0000) ^ {12'h000, alu_c}, and increment pat_cnt.
REQ-021 SHALL complete a run in exactly 2*NUM_PAT cycles from the first APPLY cycle to DONE entry.
REQ-022 SHALL register pass on the CAPTURE->DONE transition as (sig_next == GOLDEN_SIG), and hold it in DONE.
REQ-023 SHALL hold alu_a, alu_op and alu_b at their last values in DONE, and at 0 in IDLE.
REQ-024 SHALL, on start=1 in DONE, begin a fresh run: done drops and busy rises on the same edge.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: state=IDLE, lfsr=LFSR_SEED, alu_a=alu_op=alu_b=0, busy=done=pass=0, signature=0, pat_cnt=0.
REQ-026 SHALL, on reset asserted mid-run, abort the run with no partial result retained; after release, the block waits in IDLE for start.

Configuration
REQ-027 SHALL, with macro ALU_BIST_EXHAUSTIVE_EN defined, replace the LFSR with a 10-bit binary counter starting at 10'h000 and incrementing on CAPTURE exit; the run applies all 1024 patterns, NUM_PAT is ignored, and pat_cnt wraps to 0 at DONE entry.
REQ-028 SHALL, without ALU_BIST_EXHAUSTIVE_EN, implement the LFSR behaviour of REQ-019 and the NUM_PAT bound.

Verification
REQ-029 SHALL cover reset: rst_n low mid-run -> all outputs 0 immediately and state IDLE; after release, start runs normally.
REQ-030 SHALL cover the LFSR sequence: default seed, start -> {alu_a,alu_op,alu_b} in successive APPLY cycles = 001, 002, 004, 008, 010, 020, 040, 081.
REQ-031 SHALL cover MISR accumulation: NUM_PAT=2, alu_c held at 4'h1 -> signature=16'h0003 at DONE, pat_cnt=2, done=1 exactly 4 cycles after the first APPLY.
REQ-032 SHALL cover the pass/fail flag: alu_c held at 0, GOLDEN_SIG=0 -> pass=1; then GOLDEN_SIG=16'h0001 with the same stimulus -> pass=0.
REQ-033 SHALL cover start handling: start pulsed during CAPTURE -> ignored with the run unchanged; start in DONE -> signature cleared and new run begun.
REQ-034 SHALL cover the exhaustive build: ALU_BIST_EXHAUSTIVE_EN defined -> patterns 000..3FF applied in order and done raised after 2048 cycles.
